// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared sample type, saturation helper and echo FSM states
package fx_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {CLR, IDLE, RD, MUL, SUM, WR} echo_state_t;

  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - single-port stereo delay buffer, synchronous write, 1-clk registered read
module echo_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // rdata only moves on a read, so it holds through the rest of the frame
  always_ff @(posedge clk) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/echo_delay.sv
// rtl/echo_delay.sv - stereo echo/delay: circular buffer, feedback and wet mix, 5-clk frame FSM
module echo_delay
  import fx_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int GAIN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [15:0]       left_in,
  input  logic signed [15:0]       right_in,
  input  logic        [ADDR_W-1:0] delay_len,
  input  logic        [GAIN_W-1:0] fb_gain,
  input  logic        [GAIN_W-1:0] mix_gain,
  input  logic                     bypass,
  output logic signed [15:0]       left_out,
  output logic signed [15:0]       right_out,
  output logic                     out_strobe,
  output logic                     ready,
  output logic                     overrun
);

  localparam int PW = 17 + GAIN_W;

  echo_state_t state, state_next;
  logic              valid_q, start;
  logic [ADDR_W-1:0] clr_cnt, wr_ptr, dl;
  logic [GAIN_W-1:0] fb, mx;
  logic              byp;
  sample_t           x_l, x_r, d_l, d_r, w_l, w_r, y_l, y_r;
  logic signed [PW-1:0] p_fb_l, p_fb_r, p_mx_l, p_mx_r;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  assign start = valid_in & ~valid_q;

  echo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // A zero delay would read the slot being written this frame, so the tap is forced to 0
  assign d_l = (dl == '0) ? '0 : ram_rdata[31:16];
  assign d_r = (dl == '0) ? '0 : ram_rdata[15:0];

  function automatic logic signed [PW-1:0] gmul(input sample_t d, input logic [GAIN_W-1:0] g);
    logic signed [PW-1:0] de, ge;
    de = {{(PW-16){d[15]}}, d};
    ge = $signed({{(PW-GAIN_W){1'b0}}, g});
    return de * ge;
  endfunction

  function automatic sample_t mix(input sample_t x, input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> GAIN_W;
    return sat16(18'(x) + $signed(s[17:0]));
  endfunction

  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = wr_ptr - delay_len;
    ram_wdata  = {w_l, w_r};
    unique case (state)
      CLR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        if (clr_cnt == '1) state_next = IDLE;
      end
      IDLE: if (start) begin
        ram_en     = (delay_len != '0);
        state_next = RD;
      end
      RD:  state_next = MUL;
      MUL: state_next = SUM;
      SUM: state_next = WR;
      WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = wr_ptr;
        state_next = IDLE;
      end
      default: state_next = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLR;
      valid_q    <= 1'b0;
      clr_cnt    <= '0;
      wr_ptr     <= '0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
      left_out   <= '0;
      right_out  <= '0;
      out_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      valid_q    <= valid_in;
      out_strobe <= 1'b0;
      if (start && state != IDLE && state != CLR) overrun <= 1'b1;
      if (state == CLR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) ready <= 1'b1;
      end
      if (state == WR) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        left_out   <= y_l;
        right_out  <= y_r;
        out_strobe <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      x_l <= left_in;
      x_r <= right_in;
      dl  <= delay_len;
      fb  <= fb_gain;
      mx  <= mix_gain;
      byp <= bypass;
    end
    if (state == MUL) begin
      p_fb_l <= gmul(d_l, fb);
      p_fb_r <= gmul(d_r, fb);
      p_mx_l <= gmul(d_l, mx);
      p_mx_r <= gmul(d_r, mx);
    end
    if (state == SUM) begin
      w_l <= mix(x_l, p_fb_l);
      w_r <= mix(x_r, p_fb_r);
      y_l <= byp ? x_l : mix(x_l, p_mx_l);
      y_r <= byp ? x_r : mix(x_r, p_mx_r);
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// tb/tb_echo_delay.sv - scoreboard bench for echo_delay
module tb_echo_delay;

  localparam int ADDR_W = 12;
  localparam int GAIN_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, bypass = 1'b0;
  logic signed [15:0] left_in = '0, right_in = '0;
  logic signed [15:0] left_out, right_out;
  logic [ADDR_W-1:0] delay_len = '0;
  logic [GAIN_W-1:0] fb_gain = '0, mix_gain = '0;
  logic out_strobe, ready, overrun;

  int cyc = 0, errors = 0, checks = 0;

  typedef struct { int l; int r; int cyc; } exp_t;
  exp_t sb[$];
  int log_l[$], log_r[$];
  int mem_l[DEPTH], mem_r[DEPTH];
  int wptr = 0;

  echo_delay #(.ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .left_in(left_in), .right_in(right_in),
    .delay_len(delay_len), .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass),
    .left_out(left_out), .right_out(right_out), .out_strobe(out_strobe),
    .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
  endfunction

  // Reference frame: tap delay_len frames back, feedback into buffer, wet mix to output
  task automatic model(input int xl, input int xr, input int dlen, input int fb, input int mx,
                       input int byp, output int yl, output int yr);
    int dlv, drv, idx;
    dlv = 0; drv = 0;
    if (dlen != 0) begin
      idx = (wptr - dlen + DEPTH) % DEPTH;
      dlv = mem_l[idx];
      drv = mem_r[idx];
    end
    yl = byp ? xl : sat(xl + ((dlv * mx) >>> 8));
    yr = byp ? xr : sat(xr + ((drv * mx) >>> 8));
    mem_l[wptr] = sat(xl + ((dlv * fb) >>> 8));
    mem_r[wptr] = sat(xr + ((drv * fb) >>> 8));
    wptr = (wptr + 1) % DEPTH;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_strobe) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("left_out", left_out, e.l);
        check("right_out", right_out, e.r);
        check("latency", cyc - e.cyc, 4);
        log_l.push_back(left_out);
        log_r.push_back(right_out);
      end
    end
  end

  task automatic drive_start(input int l, input int r, input int dlen, input int fb,
                             input int mx, input int byp);
    exp_t e;
    int yl, yr;
    @(posedge clk); #1;
    left_in = 16'(l); right_in = 16'(r); delay_len = ADDR_W'(dlen);
    fb_gain = GAIN_W'(fb); mix_gain = GAIN_W'(mx); bypass = byp[0];
    valid_in = 1'b1;
    model(l, r, dlen, fb, mx, byp, yl, yr);
    e.l = yl; e.r = yr; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send_frame(input int l, input int r, input int dlen, input int fb,
                            input int mx, input int byp);
    drive_start(l, r, dlen, fb, mx, byp);
    repeat (2) @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset(input bit toggle);
    int n = 0;
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); log_l.delete(); log_r.delete();
    foreach (mem_l[i]) begin mem_l[i] = 0; mem_r[i] = 0; end
    wptr = 0;
    check("rst_left_out", left_out, 0);
    check("rst_right_out", right_out, 0);
    check("rst_ready", ready, 0);
    check("rst_overrun", overrun, 0);
    while (!ready && n < DEPTH + 100) begin
      @(posedge clk); #1;
      n++;
      if (!ready) valid_in = toggle && (n % 16 < 3);
    end
    valid_in = 1'b0;
    check("ready_clks", n, DEPTH);
    check("clr_overrun", overrun, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int exp_imp[5]  = '{16384, 0, 0, 8192, 0};
    int exp_dec[4]  = '{20000, 19921, 9960, 4980};
    int n_before;

    do_reset(1'b1);

    send_frame(1000, -1000, 0, 0, 0, 0);
    drain();
    check("dry_count", log_l.size(), 1);
    check("dry_l", log_l[0], 1000);
    check("dry_r", log_r[0], -1000);

    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send_frame((i == 0) ? 16384 : 0, 0, 3, 0, 128, 0);
    drain();
    check("impulse_count", log_l.size(), 5);
    for (int i = 0; i < 5; i++) check("impulse", log_l[i], exp_imp[i]);

    do_reset(1'b0);
    for (int i = 0; i < 4; i++) send_frame((i == 0) ? 20000 : 0, 0, 1, 128, 255, 0);
    drain();
    check("decay_count", log_l.size(), 4);
    for (int i = 0; i < 4; i++) check("decay", log_l[i], exp_dec[i]);

    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send_frame(32767, 32767, 1, 255, 255, 0);
    drain();
    for (int i = 0; i < 5; i++) check("sat_pos", log_l[i], 32767);
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send_frame(-32768, -32768, 1, 255, 255, 0);
    drain();
    for (int i = 0; i < 5; i++) check("sat_neg", log_r[i], -32768);

    do_reset(1'b0);
    n_before = log_l.size();
    drive_start(500, -500, 0, 0, 0, 0);
    @(posedge clk); #1 valid_in = 1'b0;
    @(posedge clk); #1 valid_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    repeat (8) @(posedge clk);
    drain();
    check("overrun_set", overrun, 1);
    check("overrun_one_strobe", log_l.size() - n_before, 1);

    for (int i = 0; i < DEPTH + 5; i++) begin
      int dlen;
      dlen = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 8);
      send_frame($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, dlen,
                 $urandom_range(0, 255), $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
    end
    drain();
    check("overrun_sticky", overrun, 1);

    send_frame(1234, -4321, 0, 0, 0, 0);
    drain();
    drive_start(77, 77, 2, 100, 100, 0);
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    send_frame(-7, 9, 1, 0, 255, 0);
    drain();
    check("post_reset_l", log_l[0], -7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
